axis_to_lbus_framer: RTL and testbench
======================================

Name: axis_to_lbus_framer

Overview:
- TX-side stage that converts an AXI4-Stream packet stream (data, tkeep, tlast) into a segment-style framed stream (data, ena, sop, eop, mty, err) for the downstream lane/MAC interface.
- Computes the end-of-packet empty-byte count (mty) from tkeep.
- Tracks packet boundaries for sop, flags keep violations, and decouples ready timing with a 2-entry skid buffer.
- Sits between the user AXIS TX FIFO and the segment serializer.

Parameters:
- DWIDTH, 128, data width in bits; must be 128 (16 byte lanes, 4-bit mty).
- ERR_CNT_W, 16, width of the saturating protocol-error counter.

Ports:
- clk  input  1  single clock for all logic.
- rstn  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  DWIDTH  input beat data; byte lane 15 (bits 127:120) is the first byte on the wire.
- s_axis_tkeep  input  16  byte enables, MSB-aligned (lane 15 first).
- s_axis_tlast  input  1  last beat of packet.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready; registered.
- m_data  output  DWIDTH  framed data.
- m_ena  output  1  output beat valid.
- m_sop  output  1  first beat of packet.
- m_eop  output  1  last beat of packet.
- m_mty  output  4  empty byte lanes at LSB end; nonzero only when m_eop=1.
- m_err  output  1  beat carries a keep violation.
- m_rdy  input  1  downstream accepts beat when m_ena & m_rdy.
- err_cnt  output  ERR_CNT_W  saturating count of beats with m_err=1.

Behaviour:
- Reset (rstn=0, async assert, sync release):
  - Outputs: m_ena=0, m_sop=0, m_eop=0, m_mty=0, m_err=0, m_data=0, err_cnt=0, s_axis_tready=0.
  - Skid buffer emptied; FSM=IDLE.
  - First cycle after release: s_axis_tready=1.
- Input transfer: s_axis_tvalid & s_axis_tready.
- s_axis_tready (registered) = skid not full after the current cycle's push/pop.
  - Never depends combinationally on m_rdy.
- Latency: an accepted beat appears on m_* the next cycle when the output register is free.
  - Output register is free when it is empty, or when m_rdy=1 in that cycle.
- Output register holds all m_* stable while m_ena=1 and m_rdy=0.
- Skid buffer:
  - 2 entries, FIFO order.
  - Entry width: data + 16 keep + last.
  - Push and pop in the same cycle keep occupancy unchanged.
- FSM (governs sop):
  - IDLE: accepted beat gets sop=1. tlast=1 → stay IDLE; tlast=0 → IN_PKT.
  - IN_PKT: sop=0. Beat with tlast=1 → IDLE.
  - State advances on beats leaving the skid into the output register.
- Classification per beat, with K = tkeep:
  - Non-last beat:
    - K must be 16'hFFFF; mty=0.
    - Otherwise err=1, mty=0, data passed unchanged.
  - Last beat:
    - K must be contiguous ones from bit 15 down, followed by zeros.
    - mty = 16 − popcount(K), range 0..15.
  - Last beat with K=0: err=1, mty=15.
  - Last beat with non-contiguous K:
    - err=1.
    - mty = count of zero lanes below the leading-ones run.
- err_cnt increments by 1 per output beat with m_err=1 as it is accepted (m_ena & m_rdy).
  - Saturates at all-ones.
- Error beats are still forwarded; framing (sop/eop) is never altered by errors.
- Reset mid-packet:
  - Partial packet is discarded.
  - Next accepted beat after release gets sop=1.
- s_axis_tvalid=1 while tready=0: no transfer; the input is not sampled.

Decomposition:
- Shared package (axis_lbus_pkg):
  - LANES=16, MTY_W=4.
  - KEEP_FULL=16'hFFFF.
  - FSM state typedef {IDLE, IN_PKT}.
- Sub-module keep_to_mty (combinational):
  - Input: tkeep[15:0].
  - Outputs: mty[3:0], contig (1 when K is a contiguous MSB-aligned run), zero (K==0).
- The top level contains the skid buffer, FSM, output register and error counter.

Test Plan:
- Single-beat packet: tkeep=16'hFFC0, tlast=1, m_rdy=1 → next cycle m_ena=1, sop=1, eop=1, mty=6, err=0.
- 3-beat packet with tkeeps FFFF, FFFF, FFFE (tlast on beat 3), back-to-back → sop on beat 1 only, eop on beat 3, mty=0,0,1, and no bubbles at m_rdy=1.
- Backpressure: m_rdy=0 for 5 cycles during a 4-beat stream → s_axis_tready drops after the skid fills (2 beats plus output register); m_* stays stable; no beat is lost or duplicated; order is preserved on m_rdy=1.
- Keep violations:
  - Non-last beat with tkeep=16'hFF00 → err=1, mty=0, err_cnt=1.
  - Last beat with tkeep=16'hF0F0 → err=1, err_cnt=2.
  - Last beat with tkeep=0 → err=1, mty=15, err_cnt=3.
- Reset mid-packet: assert rstn=0 after beat 2 of a 4-beat packet, then send a new packet → all outputs return to 0 asynchronously; the first post-reset beat has sop=1; err_cnt=0.
- Counter saturation (ERR_CNT_W=2 build): 5 error beats → err_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/axis_lbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_lbus_pkg : shared constants and types for the AXIS-to-LBUS path |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package axis_lbus_pkg;

    localparam int          LANES     = 16;
    localparam int          MTY_W     = 4;
    localparam logic [15:0] KEEP_FULL = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/keep_to_mty.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keep_to_mty : tkeep to empty-lane count, contiguity and zero flags    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module keep_to_mty
    import axis_lbus_pkg::*;
(
    input  logic [LANES-1:0] tkeep,
    output logic [MTY_W-1:0] mty,
    output logic             contig,
    output logic             zero
);

    logic [MTY_W-1:0] w_zeros;
    logic [LANES-1:0] w_inv;
    logic [LANES-1:0] w_inv_inc;

    // Sixteen empty lanes wraps to 0, but that case is overridden by zero below.
    always_comb begin
        w_zeros = '0;
        for (int i = 0; i < LANES; i++) begin
            w_zeros = w_zeros + {{(MTY_W-1){1'b0}}, ~tkeep[i]};
        end
    end

    // ~K must be a run of ones anchored at bit 0 for K to be MSB-aligned.
    assign w_inv     = ~tkeep;
    assign w_inv_inc = w_inv + {{(LANES-1){1'b0}}, 1'b1};
    assign zero      = (tkeep == '0);
    assign contig    = ~|(w_inv & w_inv_inc) & ~zero;
    assign mty       = zero ? {MTY_W{1'b1}} : w_zeros;

endmodule
`default_nettype wire

// File: rtl/axis_to_lbus_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_to_lbus_framer : AXIS packets to sop/eop/mty framed segments     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module axis_to_lbus_framer
    import axis_lbus_pkg::*;
#(
    parameter int DWIDTH    = 128,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DWIDTH-1:0]    s_axis_tdata,
    input  logic [LANES-1:0]     s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DWIDTH-1:0]    m_data,
    output logic                 m_ena,
    output logic                 m_sop,
    output logic                 m_eop,
    output logic [MTY_W-1:0]     m_mty,
    output logic                 m_err,
    input  logic                 m_rdy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int c_ENTRY_W = DWIDTH + LANES + 1;

    logic [c_ENTRY_W-1:0] r_mem [0:1];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic                 r_tready;
    state_t               r_state;
    logic [DWIDTH-1:0]    r_data;
    logic                 r_ena;
    logic                 r_sop;
    logic                 r_eop;
    logic [MTY_W-1:0]     r_mty;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_in_fire;
    logic                 w_skid_vld;
    logic                 w_out_free;
    logic                 w_load;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_count_nxt;
    logic [c_ENTRY_W-1:0] w_head;
    logic [DWIDTH-1:0]    w_head_data;
    logic [LANES-1:0]     w_head_keep;
    logic                 w_head_last;
    logic [MTY_W-1:0]     w_k_mty;
    logic                 w_k_contig;
    logic                 w_k_zero;
    logic                 w_err;
    logic [MTY_W-1:0]     w_mty;

    assign w_in_fire  = s_axis_tvalid & r_tready;
    assign w_skid_vld = (r_count != 2'd0);
    assign w_out_free = ~r_ena | m_rdy;

    // With an empty skid the incoming beat goes straight to the output register.
    assign w_head      = w_skid_vld ? r_mem[r_rd_ptr] : {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign w_load      = w_out_free & (w_skid_vld | w_in_fire);
    assign w_pop       = w_load & w_skid_vld;
    assign w_push      = w_in_fire & ~(w_load & ~w_skid_vld);
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    assign w_head_data = w_head[c_ENTRY_W-1 -: DWIDTH];
    assign w_head_keep = w_head[LANES:1];
    assign w_head_last = w_head[0];

    keep_to_mty u_keep_to_mty (
        .tkeep  (w_head_keep),
        .mty    (w_k_mty),
        .contig (w_k_contig),
        .zero   (w_k_zero)
    );

    assign w_err = w_head_last ? (w_k_zero | ~w_k_contig) : (w_head_keep != KEEP_FULL);
    assign w_mty = w_head_last ? w_k_mty : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_tready  <= 1'b0;
            r_state   <= IDLE;
            r_data    <= '0;
            r_ena     <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_mty     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count  <= w_count_nxt;
            r_tready <= ~w_count_nxt[1];

            if (w_load) begin
                r_data  <= w_head_data;
                r_ena   <= 1'b1;
                r_sop   <= (r_state == IDLE);
                r_eop   <= w_head_last;
                r_mty   <= w_mty;
                r_err   <= w_err;
                r_state <= w_head_last ? IDLE : IN_PKT;
            end else if (m_rdy) begin
                r_ena <= 1'b0;
                r_sop <= 1'b0;
                r_eop <= 1'b0;
                r_mty <= '0;
                r_err <= 1'b0;
            end

            if (r_ena && m_rdy && r_err && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign m_data        = r_data;
    assign m_ena         = r_ena;
    assign m_sop         = r_sop;
    assign m_eop         = r_eop;
    assign m_mty         = r_mty;
    assign m_err         = r_err;
    assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_to_lbus_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_to_lbus_framer : directed self-checking bench for the framer |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_axis_to_lbus_framer;

    logic         clk;
    logic         rstn;
    logic [127:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [127:0] m_data;
    logic         m_ena;
    logic         m_sop;
    logic         m_eop;
    logic [3:0]   m_mty;
    logic         m_err;
    logic         m_rdy;
    logic [1:0]   err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    axis_to_lbus_framer #(.DWIDTH(128), .ERR_CNT_W(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_data        (m_data),
        .m_ena         (m_ena),
        .m_sop         (m_sop),
        .m_eop         (m_eop),
        .m_mty         (m_mty),
        .m_err         (m_err),
        .m_rdy         (m_rdy),
        .err_cnt       (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flags packed as {ena, sop, eop, mty, err}.
    task automatic chk_out(input string tag, input logic [7:0] exp_flags, input logic [127:0] exp_data);
        chk({tag, ".flags"}, {120'd0, m_ena, m_sop, m_eop, m_mty, m_err}, {120'd0, exp_flags});
        if (exp_flags[7]) chk({tag, ".data"}, m_data, exp_data);
    endtask

    task automatic drive(input logic vld, input logic [127:0] d, input logic [15:0] k, input logic l);
        s_axis_tvalid = vld;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
    endtask

    initial begin
        rstn  = 1'b0;
        m_rdy = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();

        // Reset state
        chk_out("reset", 8'h00, '0);
        chk("reset.data", m_data, '0);
        chk("reset.tready", {127'd0, s_axis_tready}, 128'd0);
        chk("reset.err_cnt", {126'd0, err_cnt}, 128'd0);
        rstn = 1'b1;
        tick();
        chk("release.tready", {127'd0, s_axis_tready}, 128'd1);

        // Single-beat packet, 10 valid bytes
        drive(1'b1, 128'hA1, 16'hFFC0, 1'b1);
        tick();
        chk_out("single", {1'b1, 1'b1, 1'b1, 4'd6, 1'b0}, 128'hA1);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk_out("single.drain", 8'h00, '0);

        // Three back-to-back beats
        drive(1'b1, 128'hB1, 16'hFFFF, 1'b0);
        tick();
        chk_out("b3.beat1", {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}, 128'hB1);
        drive(1'b1, 128'hB2, 16'hFFFF, 1'b0);
        tick();
        chk_out("b3.beat2", {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}, 128'hB2);
        chk("b3.tready", {127'd0, s_axis_tready}, 128'd1);
        drive(1'b1, 128'hB3, 16'hFFFE, 1'b1);
        tick();
        chk_out("b3.beat3", {1'b1, 1'b0, 1'b1, 4'd1, 1'b0}, 128'hB3);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk_out("b3.drain", 8'h00, '0);

        // Backpressure: m_rdy low for five edges while a 4-beat packet arrives
        m_rdy = 1'b0;
        drive(1'b1, 128'hC1, 16'hFFFF, 1'b0);
        tick();
        chk_out("bp.c1", {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}, 128'hC1);
        drive(1'b1, 128'hC2, 16'hFFFF, 1'b0);
        tick();
        chk("bp.tready2", {127'd0, s_axis_tready}, 128'd1);
        chk_out("bp.hold2", {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}, 128'hC1);
        drive(1'b1, 128'hC3, 16'hFFFF, 1'b0);
        tick();
        chk("bp.tready3", {127'd0, s_axis_tready}, 128'd0);
        drive(1'b1, 128'hC4, 16'hFFFF, 1'b1);
        tick();
        chk("bp.tready4", {127'd0, s_axis_tready}, 128'd0);
        tick();
        chk_out("bp.hold5", {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}, 128'hC1);
        m_rdy = 1'b1;
        tick();
        chk_out("bp.c2", {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}, 128'hC2);
        chk("bp.tready6", {127'd0, s_axis_tready}, 128'd1);
        tick();
        chk_out("bp.c3", {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}, 128'hC3);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk_out("bp.c4", {1'b1, 1'b0, 1'b1, 4'd0, 1'b0}, 128'hC4);
        tick();
        chk_out("bp.drain", 8'h00, '0);

        // Keep violations and counter saturation (2-bit counter)
        drive(1'b1, 128'hD1, 16'hFF00, 1'b0);
        tick();
        chk_out("kv.nonlast", {1'b1, 1'b1, 1'b0, 4'd0, 1'b1}, 128'hD1);
        drive(1'b1, 128'hD2, 16'hF0F0, 1'b1);
        tick();
        chk("kv.cnt1", {126'd0, err_cnt}, 128'd1);
        chk_out("kv.noncontig", {1'b1, 1'b0, 1'b1, 4'd8, 1'b1}, 128'hD2);
        drive(1'b1, 128'hD3, 16'h0000, 1'b1);
        tick();
        chk("kv.cnt2", {126'd0, err_cnt}, 128'd2);
        chk_out("kv.zero", {1'b1, 1'b1, 1'b1, 4'd15, 1'b1}, 128'hD3);
        drive(1'b1, 128'hD4, 16'hFFFF, 1'b0);
        tick();
        chk("kv.cnt3", {126'd0, err_cnt}, 128'd3);
        chk_out("kv.good", {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}, 128'hD4);
        drive(1'b1, 128'hE1, 16'h0000, 1'b1);
        tick();
        chk_out("sat.e1", {1'b1, 1'b0, 1'b1, 4'd15, 1'b1}, 128'hE1);
        drive(1'b1, 128'hE2, 16'h0000, 1'b1);
        tick();
        chk("sat.cnt4", {126'd0, err_cnt}, 128'd3);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("sat.cnt5", {126'd0, err_cnt}, 128'd3);

        // Reset in the middle of a packet
        drive(1'b1, 128'hF1, 16'hFFFF, 1'b0);
        tick();
        drive(1'b1, 128'hF2, 16'hFFFF, 1'b0);
        tick();
        chk_out("mid.f2", {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}, 128'hF2);
        drive(1'b0, '0, '0, 1'b0);
        #1 rstn = 1'b0;
        #1;
        chk_out("mid.async", 8'h00, '0);
        chk("mid.async.data", m_data, '0);
        chk("mid.err_cnt", {126'd0, err_cnt}, 128'd0);
        tick();
        #2 rstn = 1'b1;
        tick();
        chk("mid.tready", {127'd0, s_axis_tready}, 128'd1);
        drive(1'b1, 128'h61, 16'hFFFF, 1'b1);
        tick();
        chk_out("mid.newsop", {1'b1, 1'b1, 1'b1, 4'd0, 1'b0}, 128'h61);
        drive(1'b0, '0, '0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
